// File: rtl/arq_seqn_ctrl_if.sv
// Signal bundle between the baseband RX/TX sequencer and the per-link ARQ/SEQN/FLOW
// bookkeeping block; the sequencer side is the master.
interface arq_seqn_ctrl_if #(parameter int NLT = 8);
    logic           pk_encode;
    logic           hec_endp;
    logic           dec_hecgood;
    logic [2:0]     dec_lt_addr;
    logic           dec_arqn_bit;
    logic           dec_flow_bit;
    logic           dec_seqn_bit;
    logic           pktype_data;
    logic           py_endp;
    logic           dec_crcgood;
    logic [2:0]     ms_lt_addr;
    logic           tx_packet_st_p;
    logic           regi_txdatready;
    logic           regi_aclrxbufempty;
    logic           regi_flush_p;
    logic [2:0]     regi_flush_lt;
    logic [NLT-1:0] dec_arqn;
    logic [NLT-1:0] dec_flow;
    logic           sendnewpy;
    logic           tx_seqn;
    logic           tx_arqn;
    logic           tx_flow;
    logic           rx_newpy_p;
    logic           rx_dup_p;

    modport master (
        output pk_encode, hec_endp, dec_hecgood, dec_lt_addr, dec_arqn_bit, dec_flow_bit,
               dec_seqn_bit, pktype_data, py_endp, dec_crcgood, ms_lt_addr, tx_packet_st_p,
               regi_txdatready, regi_aclrxbufempty, regi_flush_p, regi_flush_lt,
        input  dec_arqn, dec_flow, sendnewpy, tx_seqn, tx_arqn, tx_flow, rx_newpy_p, rx_dup_p
    );

    modport slave (
        input  pk_encode, hec_endp, dec_hecgood, dec_lt_addr, dec_arqn_bit, dec_flow_bit,
               dec_seqn_bit, pktype_data, py_endp, dec_crcgood, ms_lt_addr, tx_packet_st_p,
               regi_txdatready, regi_aclrxbufempty, regi_flush_p, regi_flush_lt,
        output dec_arqn, dec_flow, sendnewpy, tx_seqn, tx_arqn, tx_flow, rx_newpy_p, rx_dup_p
    );
endinterface

// File: rtl/arq_seqn_ctrl.sv
// Per-LT_ADDR ARQ/SEQN/FLOW bookkeeping: tracks received ACK/FLOW, filters duplicate
// payloads by SEQN, and produces the TX header bits plus the sendnewpy buffer-swap request.
module arq_seqn_ctrl #(
    parameter int NLT = 8
) (
    input logic            clk_6M,
    input logic            rstz,
    arq_seqn_ctrl_if.slave bus
);

    logic [NLT-1:0] dec_arqn_q, dec_arqn_d;
    logic [NLT-1:0] dec_flow_q, dec_flow_d;
    logic [NLT-1:0] seqn_tx_q, seqn_tx_d;
    logic [NLT-1:0] last_seqn_q, last_seqn_d;
    logic [NLT-1:0] first_rx_q, first_rx_d;
    logic [NLT-1:0] ack_pend_q, ack_pend_d;

    logic       hold_valid_q, hold_valid_d;
    logic       hold_seqn_q, hold_seqn_d;
    logic [2:0] hold_lt_q, hold_lt_d;

    logic sendnewpy_q, sendnewpy_d;
    logic tx_seqn_q, tx_seqn_d;
    logic tx_arqn_q, tx_arqn_d;
    logic tx_flow_q, tx_flow_d;
    logic rx_newpy_q, rx_newpy_d;
    logic rx_dup_q, rx_dup_d;

    logic       rx_phase;
    logic       hdr_ok;
    logic       hec_bad;
    logic       py_chk;
    logic [2:0] ms;
    logic [2:0] fl;

    assign rx_phase = ~bus.pk_encode;
    assign hdr_ok   = bus.hec_endp & rx_phase & bus.dec_hecgood;
    assign hec_bad  = bus.hec_endp & rx_phase & ~bus.dec_hecgood;
    assign py_chk   = bus.py_endp & rx_phase & hold_valid_q & bus.pktype_data;
    assign ms       = bus.ms_lt_addr;
    assign fl       = bus.regi_flush_lt;

    // Later statements override earlier ones: payload/HEC, then TX start, then flush.
    always_comb begin
        dec_arqn_d   = dec_arqn_q;
        dec_flow_d   = dec_flow_q;
        seqn_tx_d    = seqn_tx_q;
        last_seqn_d  = last_seqn_q;
        first_rx_d   = first_rx_q;
        ack_pend_d   = ack_pend_q;
        hold_valid_d = hold_valid_q;
        hold_seqn_d  = hold_seqn_q;
        hold_lt_d    = hold_lt_q;
        sendnewpy_d  = sendnewpy_q;
        tx_seqn_d    = tx_seqn_q;
        tx_arqn_d    = tx_arqn_q;
        tx_flow_d    = tx_flow_q;
        rx_newpy_d   = 1'b0;
        rx_dup_d     = 1'b0;

        if (bus.py_endp && rx_phase) begin
            hold_valid_d = 1'b0;
        end

        if (hdr_ok) begin
            hold_valid_d = 1'b1;
            hold_seqn_d  = bus.dec_seqn_bit;
            hold_lt_d    = bus.dec_lt_addr;
            if (bus.dec_lt_addr != 3'd0) begin
                dec_arqn_d[bus.dec_lt_addr] = bus.dec_arqn_bit;
                dec_flow_d[bus.dec_lt_addr] = bus.dec_flow_bit;
            end
        end

        if (hec_bad) begin
            hold_valid_d   = 1'b0;
            ack_pend_d[ms] = 1'b0;
        end

        // Broadcast payloads are SEQN-filtered but never acknowledged.
        if (py_chk) begin
            if (!bus.dec_crcgood) begin
                ack_pend_d[hold_lt_q] = 1'b0;
            end else if (first_rx_q[hold_lt_q] || (hold_seqn_q != last_seqn_q[hold_lt_q])) begin
                last_seqn_d[hold_lt_q] = hold_seqn_q;
                first_rx_d[hold_lt_q]  = 1'b0;
                if (hold_lt_q != 3'd0) begin
                    ack_pend_d[hold_lt_q] = 1'b1;
                end
                rx_newpy_d = 1'b1;
            end else begin
                if (hold_lt_q != 3'd0) begin
                    ack_pend_d[hold_lt_q] = 1'b1;
                end
                rx_dup_d = 1'b1;
            end
        end

        if (rx_phase) begin
            sendnewpy_d = dec_arqn_q[ms] & dec_flow_q[ms] & bus.regi_txdatready;
        end

        if (bus.tx_packet_st_p) begin
            tx_arqn_d      = ack_pend_q[ms];
            ack_pend_d[ms] = 1'b0;
            tx_flow_d      = bus.regi_aclrxbufempty;
            if (sendnewpy_q) begin
                seqn_tx_d[ms] = ~seqn_tx_q[ms];
                dec_arqn_d[ms] = 1'b0;
                tx_seqn_d     = ~seqn_tx_q[ms];
            end else begin
                tx_seqn_d = seqn_tx_q[ms];
            end
        end

        if (bus.regi_flush_p) begin
            seqn_tx_d[fl]  = 1'b1;
            first_rx_d[fl] = 1'b1;
            ack_pend_d[fl] = 1'b0;
            dec_arqn_d[fl] = 1'b0;
            dec_flow_d[fl] = 1'b1;
            if (py_chk && (hold_lt_q == fl)) begin
                rx_newpy_d = 1'b0;
                rx_dup_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            dec_arqn_q   <= '0;
            dec_flow_q   <= '1;
            seqn_tx_q    <= '1;
            last_seqn_q  <= '0;
            first_rx_q   <= '1;
            ack_pend_q   <= '0;
            hold_valid_q <= 1'b0;
            hold_seqn_q  <= 1'b0;
            hold_lt_q    <= 3'd0;
            sendnewpy_q  <= 1'b0;
            tx_seqn_q    <= 1'b0;
            tx_arqn_q    <= 1'b0;
            tx_flow_q    <= 1'b1;
            rx_newpy_q   <= 1'b0;
            rx_dup_q     <= 1'b0;
        end else begin
            dec_arqn_q   <= dec_arqn_d;
            dec_flow_q   <= dec_flow_d;
            seqn_tx_q    <= seqn_tx_d;
            last_seqn_q  <= last_seqn_d;
            first_rx_q   <= first_rx_d;
            ack_pend_q   <= ack_pend_d;
            hold_valid_q <= hold_valid_d;
            hold_seqn_q  <= hold_seqn_d;
            hold_lt_q    <= hold_lt_d;
            sendnewpy_q  <= sendnewpy_d;
            tx_seqn_q    <= tx_seqn_d;
            tx_arqn_q    <= tx_arqn_d;
            tx_flow_q    <= tx_flow_d;
            rx_newpy_q   <= rx_newpy_d;
            rx_dup_q     <= rx_dup_d;
        end
    end

    assign bus.dec_arqn   = dec_arqn_q;
    assign bus.dec_flow   = dec_flow_q;
    assign bus.sendnewpy  = sendnewpy_q;
    assign bus.tx_seqn    = tx_seqn_q;
    assign bus.tx_arqn    = tx_arqn_q;
    assign bus.tx_flow    = tx_flow_q;
    assign bus.rx_newpy_p = rx_newpy_q;
    assign bus.rx_dup_p   = rx_dup_q;

endmodule

// File: tb/tb_arq_seqn_ctrl.sv
// Bench for arq_seqn_ctrl: directed link scenarios with literal expectations, then random
// traffic, all shadowed by a per-link behavioural model compared on every falling edge.
module tb_arq_seqn_ctrl;
    localparam int NLT = 8;

    logic clk_6M = 1'b0;
    logic rstz;
    always #5 clk_6M = ~clk_6M;

    arq_seqn_ctrl_if #(.NLT(NLT)) bus();
    arq_seqn_ctrl #(.NLT(NLT)) dut (.clk_6M(clk_6M), .rstz(rstz), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    bit [NLT-1:0] m_arqn, m_flow, m_stx, m_last, m_first, m_pend;
    bit m_hold_v, m_hold_seqn;
    int m_hold_lt;
    bit m_snp, m_tseqn, m_tarqn, m_tflow, m_newpy, m_dup;

    task automatic check_vec(input string name, input logic [NLT-1:0] act, input logic [NLT-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_arqn = '0; m_flow = '1; m_stx = '1; m_last = '0; m_first = '1; m_pend = '0;
        m_hold_v = 0; m_hold_seqn = 0; m_hold_lt = 0;
        m_snp = 0; m_tseqn = 0; m_tarqn = 0; m_tflow = 1; m_newpy = 0; m_dup = 0;
    endtask

    // Each link's next state is decided link by link from the events aimed at it.
    task automatic model_step();
        bit [NLT-1:0] o_arqn, o_flow, o_stx, o_last, o_first, o_pend;
        bit rx_ph, hdr_ok, hec_bad, py_chk, newpy, dup;
        int ms, lt_hdr, fl;
        o_arqn = m_arqn; o_flow = m_flow; o_stx = m_stx;
        o_last = m_last; o_first = m_first; o_pend = m_pend;
        rx_ph   = !bus.pk_encode;
        hdr_ok  = bus.hec_endp && rx_ph && bus.dec_hecgood;
        hec_bad = bus.hec_endp && rx_ph && !bus.dec_hecgood;
        py_chk  = bus.py_endp && rx_ph && m_hold_v && bus.pktype_data;
        ms = int'(bus.ms_lt_addr);
        lt_hdr = int'(bus.dec_lt_addr);
        fl = int'(bus.regi_flush_lt);
        newpy = 0;
        dup = 0;
        for (int L = 0; L < NLT; L++) begin
            if (hdr_ok && lt_hdr == L && L != 0) begin
                m_arqn[L] = bus.dec_arqn_bit;
                m_flow[L] = bus.dec_flow_bit;
            end
            if (hec_bad && ms == L) m_pend[L] = 0;
            if (py_chk && m_hold_lt == L) begin
                if (!bus.dec_crcgood) begin
                    m_pend[L] = 0;
                end else if (o_first[L] || m_hold_seqn != o_last[L]) begin
                    m_last[L] = m_hold_seqn;
                    m_first[L] = 0;
                    if (L != 0) m_pend[L] = 1;
                    newpy = 1;
                end else begin
                    if (L != 0) m_pend[L] = 1;
                    dup = 1;
                end
            end
            if (bus.tx_packet_st_p && ms == L) begin
                m_pend[L] = 0;
                if (m_snp) begin
                    m_stx[L] = !o_stx[L];
                    m_arqn[L] = 0;
                end
            end
            if (bus.regi_flush_p && fl == L) begin
                m_stx[L] = 1; m_first[L] = 1; m_pend[L] = 0; m_arqn[L] = 0; m_flow[L] = 1;
                if (py_chk && m_hold_lt == L) begin
                    newpy = 0;
                    dup = 0;
                end
            end
        end
        if (bus.tx_packet_st_p) begin
            m_tarqn = o_pend[ms];
            m_tflow = bus.regi_aclrxbufempty;
            m_tseqn = m_snp ? !o_stx[ms] : o_stx[ms];
        end
        if (rx_ph) m_snp = o_arqn[ms] & o_flow[ms] & bus.regi_txdatready;
        if (hdr_ok) begin
            m_hold_v = 1;
            m_hold_seqn = bus.dec_seqn_bit;
            m_hold_lt = lt_hdr;
        end else if (hec_bad || (bus.py_endp && rx_ph)) begin
            m_hold_v = 0;
        end
        m_newpy = newpy;
        m_dup = dup;
    endtask

    always @(posedge clk_6M or negedge rstz) begin
        if (!rstz) model_reset();
        else model_step();
    end

    always @(negedge clk_6M) begin
        check_vec("model dec_arqn", bus.dec_arqn, m_arqn);
        check_vec("model dec_flow", bus.dec_flow, m_flow);
        check_bit("model sendnewpy", bus.sendnewpy, m_snp);
        check_bit("model tx_seqn", bus.tx_seqn, m_tseqn);
        check_bit("model tx_arqn", bus.tx_arqn, m_tarqn);
        check_bit("model tx_flow", bus.tx_flow, m_tflow);
        check_bit("model rx_newpy_p", bus.rx_newpy_p, m_newpy);
        check_bit("model rx_dup_p", bus.rx_dup_p, m_dup);
    end

    task automatic rx_packet(input logic [2:0] lt, input bit arqn, input bit flow, input bit seqn,
                             input bit hecgood, input bit crcgood, input bit flush,
                             output bit newpy, output bit dup);
        @(negedge clk_6M);
        bus.pk_encode = 0; bus.hec_endp = 1; bus.dec_hecgood = hecgood; bus.dec_lt_addr = lt;
        bus.dec_arqn_bit = arqn; bus.dec_flow_bit = flow; bus.dec_seqn_bit = seqn; bus.pktype_data = 1;
        @(negedge clk_6M);
        bus.hec_endp = 0;
        @(negedge clk_6M);
        bus.py_endp = 1; bus.dec_crcgood = crcgood;
        if (flush) begin
            bus.regi_flush_p = 1;
            bus.regi_flush_lt = lt;
        end
        @(negedge clk_6M);
        bus.py_endp = 0; bus.regi_flush_p = 0;
        newpy = bus.rx_newpy_p;
        dup = bus.rx_dup_p;
    endtask

    task automatic tx_packet(output bit snp);
        @(negedge clk_6M);
        bus.pk_encode = 1;
        @(negedge clk_6M);
        bus.tx_packet_st_p = 1;
        snp = bus.sendnewpy;
        @(negedge clk_6M);
        bus.tx_packet_st_p = 0;
        @(negedge clk_6M);
        bus.pk_encode = 0;
    endtask

    task automatic apply_stimulus();
        bus.hec_endp = 0; bus.py_endp = 0; bus.tx_packet_st_p = 0; bus.regi_flush_p = 0;
        if ($urandom_range(0, 15) == 0) bus.pk_encode = ~bus.pk_encode;
        if ($urandom_range(0, 7) == 0) bus.ms_lt_addr = 3'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) bus.regi_txdatready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) bus.regi_aclrxbufempty = 1'($urandom_range(0, 1));
        if (!bus.pk_encode) begin
            case ($urandom_range(0, 5))
                0: begin
                    bus.hec_endp = 1;
                    bus.dec_hecgood = ($urandom_range(0, 5) != 0);
                    bus.dec_lt_addr = 3'($urandom_range(0, 3));
                    bus.dec_arqn_bit = 1'($urandom_range(0, 1));
                    bus.dec_flow_bit = ($urandom_range(0, 3) != 0);
                    bus.dec_seqn_bit = 1'($urandom_range(0, 1));
                    bus.pktype_data = ($urandom_range(0, 4) != 0);
                end
                1: begin
                    bus.py_endp = 1;
                    bus.dec_crcgood = ($urandom_range(0, 4) != 0);
                end
                default: ;
            endcase
        end else if ($urandom_range(0, 5) == 0) begin
            bus.tx_packet_st_p = 1;
        end
        if ($urandom_range(0, 40) == 0) begin
            bus.regi_flush_p = 1;
            bus.regi_flush_lt = 3'($urandom_range(0, 3));
        end
    endtask

    bit np, dp, snp;

    initial begin
        rstz = 1;
        #1 rstz = 0;
        bus.pk_encode = 0; bus.hec_endp = 0; bus.dec_hecgood = 0; bus.dec_lt_addr = 0;
        bus.dec_arqn_bit = 0; bus.dec_flow_bit = 0; bus.dec_seqn_bit = 0; bus.pktype_data = 0;
        bus.py_endp = 0; bus.dec_crcgood = 0; bus.ms_lt_addr = 3; bus.tx_packet_st_p = 0;
        bus.regi_txdatready = 0; bus.regi_aclrxbufempty = 1; bus.regi_flush_p = 0; bus.regi_flush_lt = 0;
        repeat (3) @(negedge clk_6M);
        #2 rstz = 1;
        check_vec("reset dec_arqn", bus.dec_arqn, 8'h00);
        check_vec("reset dec_flow", bus.dec_flow, 8'hFF);
        check_bit("reset tx_flow", bus.tx_flow, 1'b1);
        check_bit("reset sendnewpy", bus.sendnewpy, 1'b0);

        // New payload on link 3, then an identical retransmission
        rx_packet(3, 1, 1, 1, 1, 1, 0, np, dp);
        check_bit("new rx_newpy_p", np, 1'b1);
        check_bit("new rx_dup_p", dp, 1'b0);
        check_vec("new dec_arqn", bus.dec_arqn, 8'h08);
        check_vec("new dec_flow", bus.dec_flow, 8'hFF);
        tx_packet(snp);
        check_bit("ack tx_arqn", bus.tx_arqn, 1'b1);
        check_bit("ack tx_seqn", bus.tx_seqn, 1'b1);
        rx_packet(3, 1, 1, 1, 1, 1, 0, np, dp);
        check_bit("dup rx_dup_p", dp, 1'b1);
        check_bit("dup rx_newpy_p", np, 1'b0);
        tx_packet(snp);
        check_bit("dup tx_arqn", bus.tx_arqn, 1'b1);

        // Buffer swap and subsequent retransmission
        bus.regi_txdatready = 1;
        repeat (2) @(negedge clk_6M);
        tx_packet(snp);
        check_bit("swap sendnewpy", snp, 1'b1);
        check_bit("swap tx_seqn", bus.tx_seqn, 1'b0);
        check_vec("swap dec_arqn", bus.dec_arqn, 8'h00);
        tx_packet(snp);
        check_bit("retx sendnewpy", snp, 1'b0);
        check_bit("retx tx_seqn", bus.tx_seqn, 1'b0);

        // FLOW stop, bad CRC, HEC failure
        rx_packet(3, 1, 0, 0, 1, 1, 0, np, dp);
        check_bit("stop rx_newpy_p", np, 1'b1);
        check_vec("stop dec_flow", bus.dec_flow, 8'hF7);
        rx_packet(3, 1, 0, 1, 1, 0, 0, np, dp);
        check_bit("badcrc no pulse", np | dp, 1'b0);
        tx_packet(snp);
        check_bit("stop sendnewpy", snp, 1'b0);
        check_bit("badcrc tx_arqn", bus.tx_arqn, 1'b0);
        rx_packet(3, 1, 0, 1, 1, 1, 0, np, dp);
        check_bit("pre-hec rx_newpy_p", np, 1'b1);
        rx_packet(3, 0, 1, 0, 0, 1, 0, np, dp);
        check_bit("hecfail no pulse", np | dp, 1'b0);
        check_vec("hecfail dec_arqn", bus.dec_arqn, 8'h08);
        check_vec("hecfail dec_flow", bus.dec_flow, 8'hF7);
        bus.regi_aclrxbufempty = 0;
        tx_packet(snp);
        check_bit("hecfail tx_arqn", bus.tx_arqn, 1'b0);
        check_bit("busy tx_flow", bus.tx_flow, 1'b0);
        bus.regi_aclrxbufempty = 1;

        // Flush coinciding with payload end; seqn 1 would otherwise be a duplicate
        rx_packet(3, 1, 0, 1, 1, 1, 1, np, dp);
        check_bit("flush no pulse", np | dp, 1'b0);
        check_vec("flush dec_arqn", bus.dec_arqn, 8'h00);
        check_vec("flush dec_flow", bus.dec_flow, 8'hFF);
        rx_packet(3, 0, 1, 1, 1, 1, 0, np, dp);
        check_bit("flush first_rx", np, 1'b1);
        tx_packet(snp);
        check_bit("flush tx_seqn", bus.tx_seqn, 1'b1);
        rx_packet(3, 0, 1, 0, 1, 1, 0, np, dp);
        check_bit("seqn0 rx_newpy_p", np, 1'b1);

        // Reset between header and payload end
        @(negedge clk_6M);
        bus.hec_endp = 1; bus.dec_hecgood = 1; bus.dec_lt_addr = 3; bus.dec_seqn_bit = 0;
        bus.dec_arqn_bit = 1; bus.dec_flow_bit = 0;
        @(negedge clk_6M);
        bus.hec_endp = 0;
        #2 rstz = 0;
        @(negedge clk_6M);
        check_vec("midrst dec_arqn", bus.dec_arqn, 8'h00);
        check_vec("midrst dec_flow", bus.dec_flow, 8'hFF);
        check_bit("midrst tx_flow", bus.tx_flow, 1'b1);
        bus.py_endp = 1; bus.dec_crcgood = 1;
        @(negedge clk_6M);
        bus.py_endp = 0;
        check_bit("midrst no pulse", bus.rx_newpy_p | bus.rx_dup_p, 1'b0);
        #2 rstz = 1;
        rx_packet(3, 0, 1, 0, 1, 1, 0, np, dp);
        check_bit("postrst rx_newpy_p", np, 1'b1);

        // Broadcast slot
        bus.ms_lt_addr = 0;
        rx_packet(0, 1, 0, 1, 1, 1, 0, np, dp);
        check_bit("bcast rx_newpy_p", np, 1'b1);
        check_vec("bcast dec_arqn", bus.dec_arqn, 8'h00);
        check_vec("bcast dec_flow", bus.dec_flow, 8'hFF);
        rx_packet(0, 1, 0, 1, 1, 1, 0, np, dp);
        check_bit("bcast rx_dup_p", dp, 1'b1);
        tx_packet(snp);
        check_bit("bcast tx_arqn", bus.tx_arqn, 1'b0);
        check_bit("bcast tx_seqn", bus.tx_seqn, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_6M);
            if ($urandom_range(0, 600) == 0) begin
                bus.hec_endp = 0; bus.py_endp = 0; bus.tx_packet_st_p = 0; bus.regi_flush_p = 0;
                #2 rstz = 0;
                #6 rstz = 1;
            end else begin
                apply_stimulus();
            end
        end
        @(negedge clk_6M);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
